// File: rtl/sort_sched_pkg.sv
// sort_sched_pkg: shared widths, state encodings and channel IDs for the frame sort scheduler
package sort_sched_pkg;
    localparam int DW     = 9;
    localparam int N_ELEM = 6;
    localparam int CNT_W  = 3;
    localparam int SW     = 10;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
    typedef enum logic [1:0] {C_IDLE, C_LOAD, C_PEND} ch_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SORT, S_OUT} sched_state_t;
endpackage

// File: rtl/sort_sched_if.sv
// sort_sched_if: both requester channels plus the shared result stream
interface sort_sched_if;
    import sort_sched_pkg::*;
    logic             in_valid_0, in_valid_1;
    logic             mode_0, mode_1;
    logic [DW-1:0]    data_in_0, data_in_1;
    logic             busy_0, busy_1;
    logic             out_ready, out_valid, out_id, out_last;
    logic [DW-1:0]    data_out;
    logic [CNT_W-1:0] output_counter;
    modport master (
        output in_valid_0, in_valid_1, mode_0, mode_1, data_in_0, data_in_1, out_ready,
        input  busy_0, busy_1, out_valid, out_id, out_last, data_out, output_counter
    );
    modport slave (
        input  in_valid_0, in_valid_1, mode_0, mode_1, data_in_0, data_in_1, out_ready,
        output busy_0, busy_1, out_valid, out_id, out_last, data_out, output_counter
    );
endinterface

// File: rtl/sort.sv
// sort: combinational descending sort of N words via odd-even transposition
module sort #(
    parameter int W = 10,
    parameter int N = 6
) (
    input  logic [N*W-1:0] din,
    output logic [N*W-1:0] dout
);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    // N alternating compare-exchange passes fully order N words, larger words move toward index 0
    always_comb begin
        t = '0;
        for (int i = 0; i < N; i++) a[i] = din[i*W +: W];
        for (int p = 0; p < N; p++)
            for (int i = 0; i < N - 1; i++)
                if ((i % 2) == (p % 2) && a[i] < a[i+1]) begin
                    t = a[i];
                    a[i] = a[i+1];
                    a[i+1] = t;
                end
        for (int i = 0; i < N; i++) dout[i*W +: W] = a[i];
    end
endmodule

// File: rtl/sort_sched_ch_buf.sv
// sort_sched_ch_buf: captures one 6-word frame and its mode, holds it until the scheduler releases it
module sort_sched_ch_buf
    import sort_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 mode_in,
    input  logic [DW-1:0]        data_in,
    input  logic                 rel,
    output logic                 pend,
    output logic                 mode,
    output logic [N_ELEM*DW-1:0] buf_flat
);
    ch_state_t        st;
    logic [CNT_W-1:0] wcnt;
    logic [DW-1:0]    mem [N_ELEM];

    assign pend = (st == C_PEND);

    // flatten the word buffer for the scheduler mux
    always_comb for (int i = 0; i < N_ELEM; i++) buf_flat[i*DW +: DW] = mem[i];

    // capture FSM: words are only accepted outside C_PEND, so input while busy is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= C_IDLE;
            wcnt <= '0;
            mode <= 1'b0;
        end else begin
            case (st)
                C_IDLE: if (in_valid) begin
                    mem[0] <= data_in;
                    mode   <= mode_in;
                    wcnt   <= CNT_W'(1);
                    st     <= C_LOAD;
                end
                C_LOAD: if (in_valid) begin
                    mem[wcnt] <= data_in;
                    wcnt      <= wcnt + 1'b1;
                    if (wcnt == LAST_IDX) st <= C_PEND;
                end
                C_PEND: if (rel) st <= C_IDLE;
                default: st <= C_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/sort_sched.sv
// sort_sched: round-robin scheduler sharing one sort network between two frame channels
module sort_sched
    import sort_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    sort_sched_if.slave bus
);
    logic [1:0]           pend, mode_q, rel;
    logic [N_ELEM*DW-1:0] bufs [2];
    logic [N_ELEM*SW-1:0] srt_in, srt_out;
    logic [DW-1:0]        res [N_ELEM];
    sched_state_t         st;
    logic                 id, last_grant, gsel, ov;
    logic [CNT_W-1:0]     idx;

    sort_sched_ch_buf u_ch0 (
        .clk, .rst, .in_valid(bus.in_valid_0), .mode_in(bus.mode_0), .data_in(bus.data_in_0),
        .rel(rel[0]), .pend(pend[0]), .mode(mode_q[0]), .buf_flat(bufs[0])
    );
    sort_sched_ch_buf u_ch1 (
        .clk, .rst, .in_valid(bus.in_valid_1), .mode_in(bus.mode_1), .data_in(bus.data_in_1),
        .rel(rel[1]), .pend(pend[1]), .mode(mode_q[1]), .buf_flat(bufs[1])
    );
    sort #(.W(SW), .N(N_ELEM)) u_sort (.din(srt_in), .dout(srt_out));

    assign bus.out_valid      = ov;
    assign bus.out_id         = id;
    assign bus.output_counter = idx;
    assign bus.data_out       = res[idx];
    assign bus.out_last       = ov && (idx == LAST_IDX);
    assign bus.busy_0         = pend[0];
    assign bus.busy_1         = pend[1];

    // grant choice, release on final accepted beat, zero-extended sort operands from the granted buffer
    always_comb begin
        gsel    = (&pend) ? ~last_grant : pend[1];
        rel     = '0;
        rel[id] = (st == S_OUT) && bus.out_ready && (idx == LAST_IDX);
        for (int i = 0; i < N_ELEM; i++) srt_in[i*SW +: SW] = SW'(bufs[id][i*DW +: DW]);
    end

    // scheduler: grant, optional one-cycle sort, then stream six beats under out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            id         <= CH0;
            last_grant <= CH1;
            idx        <= '0;
            ov         <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) res[i] <= '0;
        end else begin
            case (st)
                S_IDLE: if (|pend) begin
                    id  <= gsel;
                    idx <= '0;
                    if (mode_q[gsel]) st <= S_SORT;
                    else begin
                        for (int i = 0; i < N_ELEM; i++) res[i] <= bufs[gsel][i*DW +: DW];
                        ov <= 1'b1;
                        st <= S_OUT;
                    end
                end
                S_SORT: begin
                    for (int i = 0; i < N_ELEM; i++) res[i] <= DW'(srt_out[i*SW +: SW]);
                    ov <= 1'b1;
                    st <= S_OUT;
                end
                S_OUT: if (bus.out_ready) begin
                    if (idx == LAST_IDX) begin
                        ov         <= 1'b0;
                        last_grant <= id;
                        idx        <= '0;
                        st         <= S_IDLE;
                    end else idx <= idx + 1'b1;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_sched.sv
// tb_sort_sched: directed and randomized frame traffic checked against a frame-level reference model
module tb_sort_sched;
    logic clk, rst;
    int n_checks, n_fail;
    int rdy_mode;
    int rk;
    logic [53:0] eq0[$], eq1[$];
    int rp0, rp1;
    int done_ids[$];
    int b, gap, last_gap, n99;
    logic fid, pv_stall, p_last;
    logic [8:0] pd;
    logic [2:0] pc;
    logic [53:0] ef;
    bit have;

    sort_sched_if sif();
    sort_sched dut (.clk(clk), .rst(rst), .bus(sif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [53:0] pk(input int a, input int c, input int d, input int e, input int f, input int g);
        return {9'(g), 9'(f), 9'(e), 9'(d), 9'(c), 9'(a)};
    endfunction

    function automatic logic [53:0] rnd_frame();
        logic [53:0] r;
        int hi;
        hi = ($urandom_range(0, 1) == 1) ? 7 : 511;
        for (int i = 0; i < 6; i++) r[i*9 +: 9] = 9'($urandom_range(0, hi));
        return r;
    endfunction

    function automatic logic [53:0] model(input logic [53:0] f, input logic m);
        int q[$];
        logic [53:0] r;
        for (int i = 0; i < 6; i++) q.push_back(int'(f[i*9 +: 9]));
        if (m) q.rsort();
        r = '0;
        for (int i = 0; i < 6; i++) r[i*9 +: 9] = 9'(q[i]);
        return r;
    endfunction

    task automatic drv(input int ch, input logic v, input logic m, input logic [8:0] d);
        if (ch == 0) begin
            sif.in_valid_0 = v; sif.mode_0 = m; sif.data_in_0 = d;
        end else begin
            sif.in_valid_1 = v; sif.mode_1 = m; sif.data_in_1 = d;
        end
    endtask

    task automatic send_frame(input int ch, input logic m, input logic [53:0] f, input int maxgap, input bit push);
        if (push) begin
            if (ch == 0) eq0.push_back(model(f, m));
            else eq1.push_back(model(f, m));
        end
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, maxgap)) tick();
            drv(ch, 1'b1, m, f[i*9 +: 9]);
            tick();
            drv(ch, 1'b0, 1'b0, 9'd0);
        end
    endtask

    task automatic wait_free(input int ch);
        int t = 0;
        while (t < 2000 && ((ch == 0) ? sif.busy_0 : sif.busy_1)) begin tick(); t++; end
        chk("free_timeout", t < 2000, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (t < 3000 && !(rp0 == eq0.size() && rp1 == eq1.size() && !sif.out_valid && !sif.busy_0 && !sif.busy_1)) begin
            tick();
            t++;
        end
        chk("drain_timeout", t < 3000, 1);
    endtask

    task automatic do_reset();
        drv(0, 1'b0, 1'b0, 9'd0);
        drv(1, 1'b0, 1'b0, 9'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // consumer back-pressure: 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 never ready
    initial begin
        rk = 0;
        sif.out_ready = 1'b1;
        forever begin
            tick();
            rk++;
            sif.out_ready = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 1) ? 1'($urandom_range(0, 1)) :
                            (rdy_mode == 2) ? (rk % 4 == 0 || rk % 4 == 3) : 1'b0;
        end
    end

    // output monitor: beat order, counter, last flag, stall hold, idle gaps and frame contents
    always @(negedge clk) begin
        if (rst) begin
            b = 0; pv_stall = 0; p_last = 0; gap = 0;
        end else begin
            if (pv_stall) begin
                chk("hold_valid", sif.out_valid, 1);
                chk("hold_data", sif.data_out, pd);
                chk("hold_cnt", sif.output_counter, pc);
            end
            if (p_last) chk("idle_after_last", sif.out_valid, 0);
            if (!sif.out_valid) begin
                gap++;
                chk("last_low", sif.out_last, 0);
            end else begin
                if (b == 0) last_gap = gap;
                chk("counter", sif.output_counter, b);
                chk("last_flag", sif.out_last, b == 5);
                if (sif.out_ready) begin
                    if (b == 0) fid = sif.out_id;
                    else chk("id_stable", sif.out_id, fid);
                    if (sif.data_out == 9'd99) n99++;
                    have = fid ? (rp1 < eq1.size()) : (rp0 < eq0.size());
                    if (!have) chk("unexpected_beat", 1, 0);
                    else begin
                        ef = fid ? eq1[rp1] : eq0[rp0];
                        chk("beat_data", sif.data_out, ef[b*9 +: 9]);
                    end
                    b++;
                    if (b == 6) begin
                        b = 0;
                        gap = 0;
                        done_ids.push_back(int'(fid));
                        if (have) begin
                            if (fid) rp1++;
                            else rp0++;
                        end
                    end
                end
            end
            pv_stall = sif.out_valid && !sif.out_ready;
            p_last   = sif.out_valid && sif.out_ready && sif.out_last;
            pd       = sif.data_out;
            pc       = sif.output_counter;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, n99_0;
        n_checks = 0; n_fail = 0; rdy_mode = 0;
        rp0 = 0; rp1 = 0; n99 = 0; last_gap = 0;
        rst = 1'b1;
        drv(0, 1'b0, 1'b0, 9'd0);
        drv(1, 1'b0, 1'b0, 9'd0);
        repeat (3) tick();
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_id", sif.out_id, 0);
        chk("rst_data", sif.data_out, 0);
        chk("rst_cnt", sif.output_counter, 0);
        chk("rst_last", sif.out_last, 0);
        chk("rst_busy0", sif.busy_0, 0);
        chk("rst_busy1", sif.busy_1, 0);
        rst = 1'b0;
        tick();

        send_frame(0, 1'b0, pk(3, 7, 1, 9, 0, 5), 0, 1);
        chk("t1_busy", sif.busy_0, 1);
        chk("t1_g_valid", sif.out_valid, 0);
        tick();
        chk("t1_lat", sif.out_valid, 1);
        chk("t1_first", sif.data_out, 3);
        chk("t1_id", sif.out_id, 0);
        wait_done();

        send_frame(1, 1'b1, pk(12, 511, 0, 12, 44, 3), 0, 1);
        chk("t2_g_valid", sif.out_valid, 0);
        tick();
        chk("t2_g1_valid", sif.out_valid, 0);
        tick();
        chk("t2_lat", sif.out_valid, 1);
        chk("t2_first", sif.data_out, 511);
        chk("t2_id", sif.out_id, 1);
        wait_done();

        do_reset();
        n = done_ids.size();
        fork
            send_frame(0, 1'b0, rnd_frame(), 0, 1);
            send_frame(1, 1'b1, rnd_frame(), 0, 1);
        join
        wait_done();
        chk("t3a_count", done_ids.size() - n, 2);
        chk("t3a_first", done_ids[n], 0);
        chk("t3a_second", done_ids[n+1], 1);
        send_frame(0, 1'b1, rnd_frame(), 0, 1);
        wait_done();
        n = done_ids.size();
        fork
            send_frame(0, 1'b1, rnd_frame(), 0, 1);
            send_frame(1, 1'b0, rnd_frame(), 0, 1);
        join
        wait_done();
        chk("t3b_count", done_ids.size() - n, 2);
        chk("t3b_first", done_ids[n], 1);
        chk("t3b_second", done_ids[n+1], 0);

        rdy_mode = 2;
        send_frame(0, 1'b1, pk(100, 4, 250, 4, 9, 300), 0, 1);
        wait_done();
        rdy_mode = 0;

        for (int i = 0; i < 3; i++) begin
            drv(0, 1'b1, 1'b1, 9'(400 + i));
            tick();
        end
        drv(0, 1'b0, 1'b0, 9'd0);
        rst = 1'b1;
        tick();
        chk("t5_busy", sif.busy_0, 0);
        chk("t5_valid", sif.out_valid, 0);
        tick();
        rst = 1'b0;
        send_frame(0, 1'b0, pk(2, 2, 2, 2, 2, 2), 0, 1);
        wait_done();

        rdy_mode = 3;
        send_frame(1, 1'b0, rnd_frame(), 0, 0);
        repeat (3) tick();
        chk("t5b_stall_valid", sif.out_valid, 1);
        chk("t5b_stall_id", sif.out_id, 1);
        rst = 1'b1;
        tick();
        chk("t5b_rst_valid", sif.out_valid, 0);
        chk("t5b_rst_busy", sif.busy_1, 0);
        chk("t5b_rst_cnt", sif.output_counter, 0);
        rst = 1'b0;
        rdy_mode = 0;
        tick();

        rdy_mode = 2;
        n99_0 = n99;
        send_frame(0, 1'b0, pk(10, 20, 30, 40, 50, 60), 0, 1);
        n = done_ids.size();
        fork
            begin
                int t = 0;
                while (sif.busy_0 && t < 200) begin
                    drv(0, 1'b1, 1'b0, 9'd99);
                    tick();
                    t++;
                end
                drv(0, 1'b0, 1'b0, 9'd0);
                chk("t6_busy_timeout", t < 200, 1);
            end
            send_frame(1, 1'b0, pk(1, 2, 3, 4, 5, 6), 0, 1);
        join
        wait_done();
        rdy_mode = 0;
        chk("t6_no99", n99 - n99_0, 0);
        chk("t6_count", done_ids.size() - n, 2);
        chk("t6_first", done_ids[n], 0);
        chk("t6_second", done_ids[n+1], 1);
        chk("t6_gap", last_gap, 1);

        rdy_mode = 1;
        fork
            for (int k = 0; k < 8; k++) begin
                wait_free(0);
                send_frame(0, 1'($urandom_range(0, 1)), rnd_frame(), 2, 1);
            end
            for (int k = 0; k < 8; k++) begin
                wait_free(1);
                send_frame(1, 1'($urandom_range(0, 1)), rnd_frame(), 2, 1);
            end
        join
        wait_done();
        chk("rand_all_ch0", rp0, eq0.size());
        chk("rand_all_ch1", rp1, eq1.size());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
